// File: rtl/uart_cmd_responder_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_responder_pkg
// Shared definitions for the UART command-frame responder: byte width, the
// default frame opcodes and response bytes, and the FSM state encoding.
// -----------------------------------------------------------------------------
package uart_cmd_responder_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] DEF_WR_CMD   = 8'hAA;
    localparam logic [BYTE_W-1:0] DEF_RD_CMD   = 8'hBB;
    localparam logic [BYTE_W-1:0] DEF_ACK_BYTE = 8'h5A;
    localparam logic [BYTE_W-1:0] DEF_NAK_BYTE = 8'hEE;

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        REG_WR,
        REG_RD,
        WAIT_RD,
        SEND,
        WAIT_HI,
        WAIT_LO
    } state_t;

endpackage

// File: rtl/uart_cmd_responder_frame_timer.sv
// -----------------------------------------------------------------------------
// uart_frame_timer
// Inter-byte idle counter. Counts up while 'run' is high and 'clear' is low,
// saturating at TIMEOUT; 'expired' is high while the count equals TIMEOUT.
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset
//   run      in   count enable
//   clear    in   synchronous clear (wins over run)
//   expired  out  count == TIMEOUT
// -----------------------------------------------------------------------------
module uart_frame_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    assign expired = (count == CNT_W'(TIMEOUT));

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// -----------------------------------------------------------------------------
// uart_cmd_responder
// Decodes write (WR_CMD, addr, data) and read (RD_CMD, addr) frames arriving
// from the UART receiver, performs the register-file access, and answers with
// ACK, NAK or the read-data byte through the UART transmit handshake.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   rx_data/rx_valid          received byte and its one-cycle strobe
//   rx_par_err/rx_stp_err     receive errors, qualified by rx_valid
//   tx_data/tx_valid/tx_busy  transmit byte, request pulse, busy status
//   reg_addr                  register address (holds between accesses)
//   reg_wr_data/reg_wr_en     write data and one-cycle write strobe
//   reg_rd_en                 one-cycle read strobe
//   reg_rd_data/reg_rd_valid  read data and its strobe
//   frame_err                 one-cycle pulse on any NAK or timeout abort
// -----------------------------------------------------------------------------
module uart_cmd_responder
    import uart_cmd_responder_pkg::*;
#(
    parameter int                ADDR_W   = 4,
    parameter logic [BYTE_W-1:0] WR_CMD   = DEF_WR_CMD,
    parameter logic [BYTE_W-1:0] RD_CMD   = DEF_RD_CMD,
    parameter logic [BYTE_W-1:0] ACK_BYTE = DEF_ACK_BYTE,
    parameter logic [BYTE_W-1:0] NAK_BYTE = DEF_NAK_BYTE,
    parameter int                TIMEOUT  = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              rx_par_err,
    input  logic              rx_stp_err,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [BYTE_W-1:0] reg_wr_data,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    input  logic [BYTE_W-1:0] reg_rd_data,
    input  logic              reg_rd_valid,
    output logic              frame_err
);

    state_t            state;
    logic [BYTE_W-1:0] opcode;
    logic              rx_err;
    logic              counting;
    logic              tmr_clear;
    logic              tmr_expired;

    assign rx_err   = rx_par_err | rx_stp_err;
    assign counting = (state == GET_ADDR) || (state == GET_DATA);
    // Holding the timer in clear outside the counting states means every
    // entry into GET_ADDR/GET_DATA starts from zero.
    assign tmr_clear = rx_valid || !counting;

    uart_frame_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (counting),
        .clear   (tmr_clear),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            opcode      <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            // Strobes default low so each assertion below lasts one cycle.
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            tx_valid  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (!rx_err && (rx_data == WR_CMD || rx_data == RD_CMD)) begin
                            opcode <= rx_data;
                            state  <= GET_ADDR;
                        end else begin
                            tx_data   <= NAK_BYTE;
                            frame_err <= 1'b1;
                            state     <= SEND;
                        end
                    end
                end

                GET_ADDR: begin
                    if (rx_valid) begin
                        if (rx_err || ((rx_data >> ADDR_W) != '0)) begin
                            tx_data   <= NAK_BYTE;
                            frame_err <= 1'b1;
                            state     <= SEND;
                        end else begin
                            reg_addr <= rx_data[ADDR_W-1:0];
                            if (opcode == WR_CMD) begin
                                state <= GET_DATA;
                            end else begin
                                // Strobe raised on entry so it is seen in REG_RD.
                                reg_rd_en <= 1'b1;
                                state     <= REG_RD;
                            end
                        end
                    end else if (tmr_expired) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end

                GET_DATA: begin
                    if (rx_valid) begin
                        if (rx_err) begin
                            tx_data   <= NAK_BYTE;
                            frame_err <= 1'b1;
                            state     <= SEND;
                        end else begin
                            reg_wr_data <= rx_data;
                            reg_wr_en   <= 1'b1;
                            state       <= REG_WR;
                        end
                    end else if (tmr_expired) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end

                REG_WR: begin
                    tx_data <= ACK_BYTE;
                    state   <= SEND;
                end

                REG_RD: begin
                    state <= WAIT_RD;
                end

                WAIT_RD: begin
                    if (reg_rd_valid) begin
                        tx_data <= reg_rd_data;
                        state   <= SEND;
                    end
                end

                SEND: begin
                    if (!tx_busy) begin
                        tx_valid <= 1'b1;
                        state    <= WAIT_HI;
                    end
                end

                WAIT_HI: begin
                    if (tx_busy) begin
                        state <= WAIT_LO;
                    end
                end

                WAIT_LO: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_responder
// Directed bench for uart_cmd_responder. A monitor samples outputs 3 ns after
// each rising edge, counts strobes, records captured values, and models the
// UART transmitter (busy for 4 cycles after tx_valid) and the register file
// (read data two cycles after reg_rd_en). Inputs are driven 1 ns after edges.
// -----------------------------------------------------------------------------
module tb_uart_cmd_responder;
    import uart_cmd_responder_pkg::*;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 1023;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_par_err;
    logic              rx_stp_err;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_busy;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wr_data;
    logic              reg_wr_en;
    logic              reg_rd_en;
    logic [7:0]        reg_rd_data;
    logic              reg_rd_valid;
    logic              frame_err;

    // Model / stimulus drivers
    logic hold_busy      = 1'b0;
    logic model_busy     = 1'b0;
    logic model_rd_valid = 1'b0;
    logic stray_rd_valid = 1'b0;
    logic rd_model_en    = 1'b1;
    logic [7:0] rd_value = 8'hC3;

    assign tx_busy      = hold_busy | model_busy;
    assign reg_rd_valid = model_rd_valid | stray_rd_valid;

    uart_cmd_responder #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_par_err   (rx_par_err),
        .rx_stp_err   (rx_stp_err),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_busy      (tx_busy),
        .reg_addr     (reg_addr),
        .reg_wr_data  (reg_wr_data),
        .reg_wr_en    (reg_wr_en),
        .reg_rd_en    (reg_rd_en),
        .reg_rd_data  (reg_rd_data),
        .reg_rd_valid (reg_rd_valid),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    // Scoreboard counters
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_rx_cyc = 0;
    int wr_cnt = 0, rd_cnt = 0, txv_cnt = 0, ferr_cnt = 0;
    int both_cnt = 0, unstable = 0;
    int wr_lat = 0, rd_lat = 0, tx_lat = 0;
    int busy_left = 0, rd_delay = 0;
    logic [7:0] last_wr_addr = '0, last_wr_data = '0, last_rd_addr = '0;
    logic [7:0] last_tx = '0, prev_tx = '0;

    always @(posedge clk) begin
        #3;
        cyc++;
        // register-file model
        if (model_rd_valid) model_rd_valid = 1'b0;
        if (rd_delay > 0) begin
            rd_delay--;
            if (rd_delay == 0) begin
                reg_rd_data    = rd_value;
                model_rd_valid = 1'b1;
            end
        end
        if (reg_wr_en) begin
            wr_cnt++;
            last_wr_addr = 8'(reg_addr);
            last_wr_data = reg_wr_data;
            wr_lat = cyc - last_rx_cyc;
        end
        if (reg_rd_en) begin
            rd_cnt++;
            last_rd_addr = 8'(reg_addr);
            rd_lat = cyc - last_rx_cyc;
            if (rd_model_en) rd_delay = 2;
        end
        if (reg_wr_en && reg_rd_en) both_cnt++;
        // transmitter model
        if (tx_valid) begin
            txv_cnt++;
            last_tx = tx_data;
            tx_lat  = cyc - last_rx_cyc;
            if (tx_data !== prev_tx) unstable++;
            model_busy = 1'b1;
            busy_left  = 4;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) model_busy = 1'b0;
        end
        prev_tx = tx_data;
        if (frame_err) ferr_cnt++;
        if (rx_valid) last_rx_cyc = cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic par, input logic stp);
        @(posedge clk);
        #1;
        rx_data    = d;
        rx_valid   = 1'b1;
        rx_par_err = par;
        rx_stp_err = stp;
        @(posedge clk);
        #1;
        rx_data    = '0;
        rx_valid   = 1'b0;
        rx_par_err = 1'b0;
        rx_stp_err = 1'b0;
        wait_cycles(2);
    endtask

    // Bounded wait for the FSM to settle back to IDLE with the line quiet.
    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (!(dut.state == IDLE && !tx_busy) && n < budget) begin
            wait_cycles(1);
            n++;
        end
        check(tag, 32'(dut.state == IDLE), 32'd1);
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({tx_data, tx_valid, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, frame_err});
    endfunction

    initial begin
        rst        = 1'b1;
        rx_data    = '0;
        rx_valid   = 1'b0;
        rx_par_err = 1'b0;
        rx_stp_err = 1'b0;
        reg_rd_data = '0;
        wait_cycles(2);
        check("reset_outputs", out_vec(), 32'd0);
        check("reset_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        wait_cycles(2);

        // 1: write AA,03,7E
        send_byte(8'hAA, 0, 0);
        send_byte(8'h03, 0, 0);
        send_byte(8'h7E, 0, 0);
        wait_idle("t1_idle", 50);
        check("t1_wr_cnt", wr_cnt, 1);
        check("t1_wr_addr", 32'(last_wr_addr), 32'h03);
        check("t1_wr_data", 32'(last_wr_data), 32'h7E);
        check("t1_wr_lat", wr_lat, 1);
        check("t1_txv_cnt", txv_cnt, 1);
        check("t1_tx_data", 32'(last_tx), 32'h5A);
        check("t1_tx_lat_ge2", 32'(tx_lat >= 2), 32'd1);
        check("t1_ferr", ferr_cnt, 0);

        // 2: read BB,05 returning C3
        send_byte(8'hBB, 0, 0);
        send_byte(8'h05, 0, 0);
        wait_idle("t2_idle", 50);
        check("t2_rd_cnt", rd_cnt, 1);
        check("t2_rd_addr", 32'(last_rd_addr), 32'h05);
        check("t2_rd_lat", rd_lat, 1);
        check("t2_txv_cnt", txv_cnt, 2);
        check("t2_tx_data", 32'(last_tx), 32'hC3);
        check("t2_wr_cnt", wr_cnt, 1);

        // 3a: bad opcode
        send_byte(8'h12, 0, 0);
        wait_idle("t3a_idle", 50);
        check("t3a_txv_cnt", txv_cnt, 3);
        check("t3a_tx_data", 32'(last_tx), 32'hEE);
        check("t3a_ferr", ferr_cnt, 1);
        check("t3a_strobes", wr_cnt + rd_cnt, 2);

        // 3b: address with high bits set
        send_byte(8'hAA, 0, 0);
        send_byte(8'h13, 0, 0);
        wait_idle("t3b_idle", 50);
        check("t3b_txv_cnt", txv_cnt, 4);
        check("t3b_tx_data", 32'(last_tx), 32'hEE);
        check("t3b_ferr", ferr_cnt, 2);
        check("t3b_strobes", wr_cnt + rd_cnt, 2);
        check("t3b_addr_held", 32'(reg_addr), 32'h5);

        // 4a: stop error on address byte
        send_byte(8'hAA, 0, 0);
        send_byte(8'h03, 0, 1);
        wait_idle("t4a_idle", 50);
        check("t4a_txv_cnt", txv_cnt, 5);
        check("t4a_tx_data", 32'(last_tx), 32'hEE);
        check("t4a_ferr", ferr_cnt, 3);
        check("t4a_wr_cnt", wr_cnt, 1);

        // 4b: parity error on data byte
        send_byte(8'hAA, 0, 0);
        send_byte(8'h03, 0, 0);
        send_byte(8'h7E, 1, 0);
        wait_idle("t4b_idle", 50);
        check("t4b_txv_cnt", txv_cnt, 6);
        check("t4b_tx_data", 32'(last_tx), 32'hEE);
        check("t4b_ferr", ferr_cnt, 4);
        check("t4b_wr_cnt", wr_cnt, 1);

        // 5: timeout in GET_DATA, then a clean write
        send_byte(8'hAA, 0, 0);
        send_byte(8'h03, 0, 0);
        wait_cycles(TIMEOUT - 10);
        check("t5_no_early_abort", ferr_cnt, 4);
        check("t5_still_get_data", 32'(dut.state), 32'(GET_DATA));
        wait_cycles(20);
        check("t5_ferr_once", ferr_cnt, 5);
        check("t5_state_idle", 32'(dut.state), 32'(IDLE));
        check("t5_no_tx", txv_cnt, 6);
        send_byte(8'hAA, 0, 0);
        send_byte(8'h01, 0, 0);
        send_byte(8'h55, 0, 0);
        wait_idle("t5_idle", 50);
        check("t5_wr_cnt", wr_cnt, 2);
        check("t5_wr_addr", 32'(last_wr_addr), 32'h01);
        check("t5_wr_data", 32'(last_wr_data), 32'h55);
        check("t5_ack", 32'(last_tx), 32'h5A);

        // 6a: transmitter busy at SEND entry
        hold_busy = 1'b1;
        send_byte(8'hAA, 0, 0);
        send_byte(8'h02, 0, 0);
        send_byte(8'h99, 0, 0);
        wait_cycles(46);
        check("t6a_held_state", 32'(dut.state), 32'(SEND));
        check("t6a_tx_withheld", txv_cnt, 7);
        hold_busy = 1'b0;
        wait_idle("t6a_idle", 50);
        check("t6a_tx_once", txv_cnt, 8);
        check("t6a_ack", 32'(last_tx), 32'h5A);
        check("t6a_wr_cnt", wr_cnt, 3);

        // 6b: reset while waiting for read data
        rd_model_en = 1'b0;
        send_byte(8'hBB, 0, 0);
        send_byte(8'h05, 0, 0);
        wait_cycles(3);
        check("t6b_wait_rd", 32'(dut.state), 32'(WAIT_RD));
        rst = 1'b1;
        #1;
        check("t6b_reset_outputs", out_vec(), 32'd0);
        check("t6b_reset_state", 32'(dut.state), 32'(IDLE));
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(1);
        stray_rd_valid = 1'b1;
        reg_rd_data    = 8'h77;
        wait_cycles(1);
        stray_rd_valid = 1'b0;
        wait_cycles(20);
        check("t6b_no_tx", txv_cnt, 8);
        check("t6b_no_wr", wr_cnt, 3);
        check("t6b_rd_cnt", rd_cnt, 2);

        check("never_both_strobes", both_cnt, 0);
        check("tx_data_stable", unstable, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
